// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the CPU and the data-memory stage.
interface data_mem_unit_if;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        done;
    logic        stall;
    logic        misalign;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, done, stall, misalign
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, done, stall, misalign
    );
endinterface

// File: rtl/data_mem_unit.sv
// Data-memory stage for LW/SW with a fixed wait latency before the array access.
// Define DMEM_STORE_BUFFER_EN for a one-entry posted-store buffer.
module data_mem_unit #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic           clock,
    input  logic           reset,
    data_mem_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    state_t                r_state;
    state_t                w_state_nx;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nx;
    logic [15:0]           r_rdata_q;
    logic                  r_misalign;
    logic [15:0]           r_mem [DEPTH];

    logic                  w_req;
    logic                  w_wr;
    logic                  w_aligned;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_mem_we;
    logic [DEPTH_LOG2-1:0] w_mem_idx;
    logic [15:0]           w_mem_data;
    logic                  w_rq_en;
    logic [15:0]           w_rq_val;
    logic                  w_mis_nx;
    logic                  w_sb_accept;
    logic                  w_unused;

    assign w_req     = bus.mem_read | bus.mem_write;
    assign w_wr      = bus.mem_write;
    assign w_aligned = ~bus.addr[0];
    assign w_idx     = bus.addr[DEPTH_LOG2:1];
    assign w_unused  = ^bus.addr[15:DEPTH_LOG2+1];

`ifdef DMEM_STORE_BUFFER_EN
    logic                  r_sb_valid;
    logic [DEPTH_LOG2-1:0] r_sb_idx;
    logic [15:0]           r_sb_data;
    logic [3:0]            r_sb_cnt;
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_mem_we    = 1'b0;
        w_mem_idx   = w_idx;
        w_mem_data  = bus.wdata;
        w_rq_en     = 1'b0;
        w_rq_val    = 16'h0000;
        w_mis_nx    = r_misalign;
        w_sb_accept = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (!w_aligned) begin
                        w_state_nx = S_DONE;
                        w_mis_nx   = 1'b1;
                        w_rq_en    = 1'b1;
                    end
`ifdef DMEM_STORE_BUFFER_EN
                    else if (w_wr) begin
                        // Posted store completes now; a busy buffer holds it off
                        w_sb_accept = ~r_sb_valid & ~reset;
                    end else if (r_sb_valid) begin
                        if (r_sb_idx == w_idx) begin
                            w_state_nx = S_DONE;
                            w_mis_nx   = 1'b0;
                            w_rq_en    = 1'b1;
                            w_rq_val   = r_sb_data;
                        end
                    end
`endif
                    else begin
                        w_state_nx = S_WAIT;
                        w_cnt_nx   = 4'(LATENCY - 1);
                        w_mis_nx   = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nx = r_cnt - 4'd1;
                end else begin
                    w_state_nx = S_DONE;
                    w_rq_en    = 1'b1;
                    if (w_wr) w_mem_we = 1'b1;
                    else      w_rq_val = r_mem[w_idx];
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
`ifdef DMEM_STORE_BUFFER_EN
        // The FSM never writes while the buffer holds data, so one port suffices
        if (r_sb_valid && r_sb_cnt == 4'd0) begin
            w_mem_we   = 1'b1;
            w_mem_idx  = r_sb_idx;
            w_mem_data = r_sb_data;
        end
`endif
        if (reset) w_mem_we = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_rdata_q  <= 16'h0000;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_misalign <= w_mis_nx;
            if (w_rq_en) r_rdata_q <= w_rq_val;
        end
    end

    always_ff @(posedge clock) begin
        if (w_mem_we) r_mem[w_mem_idx] <= w_mem_data;
    end

`ifdef DMEM_STORE_BUFFER_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sb_valid <= 1'b0;
            r_sb_idx   <= '0;
            r_sb_data  <= 16'h0000;
            r_sb_cnt   <= 4'd0;
        end else if (w_sb_accept) begin
            r_sb_valid <= 1'b1;
            r_sb_idx   <= w_idx;
            r_sb_data  <= bus.wdata;
            r_sb_cnt   <= 4'(LATENCY);
        end else if (r_sb_valid) begin
            if (r_sb_cnt == 4'd0) r_sb_valid <= 1'b0;
            else                  r_sb_cnt   <= r_sb_cnt - 4'd1;
        end
    end
`endif

    assign bus.done     = (r_state == S_DONE) | w_sb_accept;
    assign bus.stall    = w_req & (r_state != S_DONE) & ~w_sb_accept;
    assign bus.rdata    = (r_state == S_DONE) ? r_rdata_q : 16'h0000;
    assign bus.misalign = (r_state == S_DONE) & r_misalign;
endmodule
